// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: four-digit multiplexed seven-segment scan controller.
// Holds a 16-bit hex value plus per-digit decimal points. Loads go into a
// shadow register and are committed to the displayed copy only at a frame
// boundary, so a frame never shows a mix of two values.
// Optional build macro: SSD_SCAN_BLANK_LZ_EN (leading-zero blanking on digits 3..1).
module ssd_scan_ctrl #(
    parameter logic [15:0] SCAN_DIV = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
    output logic        pending,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        frame
);

    localparam logic [15:0] DIV_LAST = SCAN_DIV - 16'd1;

    logic [15:0] div_reg, div_next;
    logic [1:0]  idx_reg, idx_next;
    logic [15:0] shadow_value_reg;
    logic [3:0]  shadow_dp_reg;
    logic [15:0] active_value_reg, active_value_next;
    logic [3:0]  active_dp_reg, active_dp_next;
    logic        pending_reg, pending_next;
    logic [7:0]  seg_reg, seg_next;
    logic [3:0]  an_reg, an_next;
    logic        frame_reg;
    logic        tick;
    logic        wrap;
    logic [3:0]  digit_nib;
    logic [3:0]  blank_vec;

    // Team hex-to-segment table, active-low, bit order a..g (MSB = a).
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Scan divider and digit index; a wrap is the tick that leaves digit 3.
    always_comb begin
        tick     = (div_reg == DIV_LAST);
        wrap     = tick && (idx_reg == 2'd3);
        div_next = tick ? 16'd0 : div_reg + 16'd1;
        idx_next = tick ? idx_reg + 2'd1 : idx_reg;
    end

    // Frame-boundary commit: a load on the wrap cycle bypasses the shadow.
    always_comb begin
        active_value_next = active_value_reg;
        active_dp_next    = active_dp_reg;
        pending_next      = pending_reg;
        if (wrap && load) begin
            active_value_next = value;
            active_dp_next    = dp_mask;
            pending_next      = 1'b0;
        end else if (load) begin
            pending_next      = 1'b1;
        end else if (wrap && pending_reg) begin
            active_value_next = shadow_value_reg;
            active_dp_next    = shadow_dp_reg;
            pending_next      = 1'b0;
        end
    end

    // Blank flags per digit; digit 0 is never blanked.
`ifdef SSD_SCAN_BLANK_LZ_EN
    genvar gi;
    assign blank_vec[0] = 1'b0;
    generate
        for (gi = 1; gi < 4; gi++) begin : g_lz
            assign blank_vec[gi] = (active_value_next[15:4*gi] == '0);
        end
    endgenerate
`else
    assign blank_vec = 4'b0000;
`endif

    // Outputs are computed from the next digit/value so an and seg switch on the same edge.
    always_comb begin
        digit_nib = active_value_next[{idx_next, 2'b00} +: 4];
        seg_next  = {hex_to_seg(digit_nib), ~active_dp_next[idx_next]};
        if (blank_vec[idx_next]) begin
            seg_next[7:1] = 7'b1111111;
        end
        an_next = ~(4'b0001 << idx_next);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg          <= 16'd0;
            idx_reg          <= 2'd0;
            shadow_value_reg <= 16'd0;
            shadow_dp_reg    <= 4'd0;
            active_value_reg <= 16'd0;
            active_dp_reg    <= 4'd0;
            pending_reg      <= 1'b0;
            seg_reg          <= 8'b00000011;
            an_reg           <= 4'b1110;
            frame_reg        <= 1'b0;
        end else begin
            div_reg          <= div_next;
            idx_reg          <= idx_next;
            if (load) begin
                shadow_value_reg <= value;
                shadow_dp_reg    <= dp_mask;
            end
            active_value_reg <= active_value_next;
            active_dp_reg    <= active_dp_next;
            pending_reg      <= pending_next;
            seg_reg          <= seg_next;
            an_reg           <= an_next;
            frame_reg        <= wrap;
        end
    end

    assign pending = pending_reg;
    assign seg     = seg_reg;
    assign an      = an_reg;
    assign frame   = frame_reg;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed testbench for ssd_scan_ctrl with SCAN_DIV=4 (16-cycle frame).
// k counts rising edges since reset release; after edge k the displayed
// digit is (k/4)%4 and wrap edges fall on multiples of 16.
module tb_ssd_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_mask = 4'b0000;
    logic        pending;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame;

    int vectors = 0;
    int miscompares = 0;
    int k = 0;

`ifdef SSD_SCAN_BLANK_LZ_EN
    localparam logic [7:0] ZERO_HI = 8'b11111111;
`else
    localparam logic [7:0] ZERO_HI = 8'b00000011;
`endif

    ssd_scan_ctrl #(.SCAN_DIV(16'd4)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_mask(dp_mask),
        .pending(pending), .seg(seg), .an(an), .frame(frame)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic wait_until(input int target);
        while (k < target) step();
    endtask

    task automatic test_reset();
        logic [3:0] exp_an;
        rst = 1'b1;
        step();
        step();
        vectors++; if (an !== 4'b1110) begin miscompares++; $display("FAIL reset_an: got %b want 1110", an); end
        vectors++; if (seg !== 8'b00000011) begin miscompares++; $display("FAIL reset_seg: got %b want 00000011", seg); end
        vectors++; if (pending !== 1'b0) begin miscompares++; $display("FAIL reset_pending: got %b want 0", pending); end
        vectors++; if (frame !== 1'b0) begin miscompares++; $display("FAIL reset_frame: got %b want 0", frame); end
        rst = 1'b0;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            exp_an = ~(4'b0001 << ((k / 4) % 4));
            vectors++; if (an !== exp_an) begin miscompares++; $display("FAIL idle_an k=%0d: got %b want %b", k, an, exp_an); end
            vectors++; if (seg !== 8'b00000011) begin miscompares++; $display("FAIL idle_seg k=%0d: got %b want 00000011", k, seg); end
            vectors++; if (frame !== (k == 16)) begin miscompares++; $display("FAIL idle_frame k=%0d: got %b want %b", k, frame, (k == 16)); end
            step();
        end
        $display("test_reset: idle scan checked through k=%0d", k);
    endtask

    task automatic test_load();
        load = 1'b1; value = 16'h8A1F; dp_mask = 4'b0100;
        step();
        load = 1'b0;
        vectors++; if (pending !== 1'b1) begin miscompares++; $display("FAIL load_pending_rise: got %b want 1", pending); end
        wait_until(31);
        vectors++; if (pending !== 1'b1) begin miscompares++; $display("FAIL load_pending_hold: got %b want 1", pending); end
        vectors++; if (seg !== 8'b00000011) begin miscompares++; $display("FAIL load_no_tear: got %b want 00000011", seg); end
        step();
        vectors++; if (pending !== 1'b0) begin miscompares++; $display("FAIL load_pending_fall: got %b want 0", pending); end
        vectors++; if (frame !== 1'b1) begin miscompares++; $display("FAIL load_frame: got %b want 1", frame); end
        vectors++; if (seg !== 8'b01110001) begin miscompares++; $display("FAIL load_d0: got %b want 01110001", seg); end
        step();
        vectors++; if (frame !== 1'b0) begin miscompares++; $display("FAIL load_frame_1cyc: got %b want 0", frame); end
        wait_until(36);
        vectors++; if (seg !== 8'b10011111) begin miscompares++; $display("FAIL load_d1: got %b want 10011111", seg); end
        vectors++; if (an !== 4'b1101) begin miscompares++; $display("FAIL load_an1: got %b want 1101", an); end
        wait_until(40);
        vectors++; if (seg !== 8'b00010000) begin miscompares++; $display("FAIL load_d2: got %b want 00010000", seg); end
        wait_until(44);
        vectors++; if (seg !== 8'b00000001) begin miscompares++; $display("FAIL load_d3: got %b want 00000001", seg); end
        vectors++; if (an !== 4'b0111) begin miscompares++; $display("FAIL load_an3: got %b want 0111", an); end
        $display("test_load: 8A1F frame checked at k=%0d", k);
    endtask

    task automatic test_back_to_back();
        load = 1'b1; value = 16'h1111; dp_mask = 4'b0000;
        step();
        value = 16'h2222;
        step();
        load = 1'b0;
        vectors++; if (seg !== 8'b00000001) begin miscompares++; $display("FAIL b2b_old_frame: got %b want 00000001", seg); end
        vectors++; if (pending !== 1'b1) begin miscompares++; $display("FAIL b2b_pending: got %b want 1", pending); end
        for (int d = 0; d < 4; d++) begin
            wait_until(48 + 4 * d);
            vectors++; if (seg !== 8'b00100101) begin miscompares++; $display("FAIL b2b_d%0d: got %b want 00100101", d, seg); end
        end
        $display("test_back_to_back: only 2222 displayed, k=%0d", k);
    endtask

    task automatic test_wrap_load();
        wait_until(63);
        load = 1'b1; value = 16'h0009; dp_mask = 4'b0000;
        step();
        load = 1'b0;
        vectors++; if (seg !== 8'b00001001) begin miscompares++; $display("FAIL wrapload_d0: got %b want 00001001", seg); end
        vectors++; if (pending !== 1'b0) begin miscompares++; $display("FAIL wrapload_pending: got %b want 0", pending); end
        vectors++; if (frame !== 1'b1) begin miscompares++; $display("FAIL wrapload_frame: got %b want 1", frame); end
        step();
        vectors++; if (pending !== 1'b0) begin miscompares++; $display("FAIL wrapload_pending2: got %b want 0", pending); end
        wait_until(68);
        vectors++; if (seg !== ZERO_HI) begin miscompares++; $display("FAIL wrapload_d1: got %b want %b", seg, ZERO_HI); end
        $display("test_wrap_load: bypass checked at k=%0d", k);
    endtask

    task automatic test_reset_mid();
        wait_until(72);
        vectors++; if (an !== 4'b1011) begin miscompares++; $display("FAIL rstmid_digit2: got %b want 1011", an); end
        load = 1'b1; value = 16'h1234; dp_mask = 4'b1111;
        step();
        vectors++; if (pending !== 1'b1) begin miscompares++; $display("FAIL rstmid_pending: got %b want 1", pending); end
        rst = 1'b1; value = 16'h5678;
        step();
        rst = 1'b0; load = 1'b0;
        vectors++; if (an !== 4'b1110) begin miscompares++; $display("FAIL rstmid_an: got %b want 1110", an); end
        vectors++; if (seg !== 8'b00000011) begin miscompares++; $display("FAIL rstmid_seg: got %b want 00000011", seg); end
        vectors++; if (pending !== 1'b0) begin miscompares++; $display("FAIL rstmid_pending0: got %b want 0", pending); end
        k = 0;
        wait_until(16);
        vectors++; if (frame !== 1'b1) begin miscompares++; $display("FAIL rstmid_frame: got %b want 1", frame); end
        vectors++; if (seg !== 8'b00000011) begin miscompares++; $display("FAIL rstmid_discard: got %b want 00000011", seg); end
        $display("test_reset_mid: pending value discarded, k=%0d", k);
    endtask

    task automatic test_blank();
        load = 1'b1; value = 16'h0050; dp_mask = 4'b0000;
        step();
        load = 1'b0;
        wait_until(32);
        vectors++; if (seg !== 8'b00000011) begin miscompares++; $display("FAIL blank_d0: got %b want 00000011", seg); end
        wait_until(36);
        vectors++; if (seg !== 8'b01001001) begin miscompares++; $display("FAIL blank_d1: got %b want 01001001", seg); end
        wait_until(40);
        vectors++; if (seg !== ZERO_HI) begin miscompares++; $display("FAIL blank_d2: got %b want %b", seg, ZERO_HI); end
        wait_until(44);
        vectors++; if (seg !== ZERO_HI) begin miscompares++; $display("FAIL blank_d3: got %b want %b", seg, ZERO_HI); end
        $display("test_blank: 0050 frame checked at k=%0d", k);
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_wrap_load();
        test_reset_mid();
        test_blank();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
